// File: rtl/aes_out_word_fifo.sv
// Block-wide FIFO between the AES core and the register bus: 128-bit blocks go in,
// 32-bit words come out, most significant word of the head block first.
module aes_out_word_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [127:0]               blk_data,
    input  logic                       blk_valid,
    output logic                       blk_ready,
    input  logic                       word_ready,
    output logic                       word_valid,
    output logic [31:0]                word_data,
    output logic [1:0]                 word_idx,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][127:0] mem;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [3:0][31:0]        head;
    logic                    push, pop, last;

    assign full       = (level == LW'(DEPTH));
    assign blk_ready  = !full;
    assign word_valid = (level != '0);
    assign push       = blk_valid && !full;
    assign pop        = word_valid && word_ready;
    assign last       = pop && (word_idx == 2'd3);

    // head[3] is [127:96], so word index 0 maps to head[3]
    assign head      = mem[rd_ptr];
    assign word_data = word_valid ? head[~word_idx] : 32'h0;

    // Storage is not reset; the pointers decide what is meaningful.
    always_ff @(posedge clock) begin
        if (push && !flush)
            mem[wr_ptr] <= blk_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            word_idx <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            word_idx <= '0;
            overflow <= 1'b0;
        end else begin
            if (blk_valid && full)
                overflow <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                word_idx <= word_idx + 2'd1;
                if (last)
                    rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !last)
                level <= level + LW'(1);
            else if (last && !push)
                level <= level - LW'(1);
        end
    end
endmodule
